// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : State and access-size encodings shared by the memory port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] c_arb_idle  = 2'd0;
    localparam logic [1:0] c_arb_fetch = 2'd1;
    localparam logic [1:0] c_arb_data  = 2'd2;

    // Access-size encoding matches the CU memsizesel field.
    localparam logic [1:0] c_msz_word  = 2'b00;
    localparam logic [1:0] c_msz_byte  = 2'b01;
    localparam logic [1:0] c_msz_half  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = c_arb_idle,
        ST_FETCH = c_arb_fetch,
        ST_DATA  = c_arb_data
    } arb_state_e;

    // A pipeline step is complete once every request raised in it has been served.
    function automatic logic step_complete(
        input logic if_req,
        input logic if_done,
        input logic dm_req,
        input logic dm_done
    );
        return (!if_req || if_done) && (!dm_req || dm_done);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Serialises IF fetches and MEM loads/stores onto one memory port
//          and strobes tick_tock when the current pipeline step is served.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [1:0]        dm_sizesel,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_sizesel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              tick_tock
);
    import mem_port_arbiter_pkg::*;

    arb_state_e r_state;
    logic       r_if_done;
    logic       r_dm_done;
    logic       w_step_done;

    assign w_step_done = step_complete(if_req, r_if_done, dm_req, r_dm_done);

    // Gated by rst so the strobe is low while reset is held, not only after it.
    assign tick_tock = !rst && (r_state == ST_IDLE) && w_step_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_sizesel <= c_msz_word;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_valid    <= 1'b0;
            dm_valid    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_step_done) begin
                        r_if_done <= 1'b0;
                        r_dm_done <= 1'b0;
                    end else if (dm_req && !r_dm_done) begin
                        // The MEM-stage instruction is older, so it wins.
                        r_state     <= ST_DATA;
                        mem_req     <= 1'b1;
                        mem_we      <= dm_we;
                        mem_addr    <= dm_addr;
                        mem_wdata   <= dm_wdata;
                        mem_sizesel <= dm_sizesel;
                    end else if (if_req && !r_if_done) begin
                        r_state     <= ST_FETCH;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= if_addr;
                        mem_wdata   <= '0;
                        mem_sizesel <= c_msz_word;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state     <= ST_IDLE;
                        r_if_done   <= 1'b1;
                        if_rdata    <= mem_rdata;
                        if_valid    <= 1'b1;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                        mem_sizesel <= c_msz_word;
                    end
                end
                ST_DATA: begin
                    if (mem_ready) begin
                        r_state     <= ST_IDLE;
                        r_dm_done   <= 1'b1;
                        dm_valid    <= 1'b1;
                        // Only loads return data; a store keeps the last load value.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                        mem_sizesel <= c_msz_word;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    mem_req     <= 1'b0;
                    mem_we      <= 1'b0;
                    mem_addr    <= '0;
                    mem_wdata   <= '0;
                    mem_sizesel <= c_msz_word;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed and random pipeline steps against a transaction-level
//          model of the shared memory port.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [1:0]        dm_sizesel;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_sizesel;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              tick_tock;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_sizesel(dm_sizesel), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sizesel(mem_sizesel), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .tick_tock(tick_tock)
    );

    always #5 clk = ~clk;

    // One memory transaction as the step's rules demand it, plus how the memory answers.
    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          wait_cyc;
        logic [31:0] rdata;
    } txn_t;

    txn_t        q[$];
    txn_t        cur;
    bit          busy;
    bit          step_end;
    bit          force_spurious;
    bit          exp_if_valid;
    bit          exp_dm_valid;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".mem_sizesel"}, {30'd0, mem_sizesel}, 32'd0);
        chk({tag, ".if_rdata"}, if_rdata, 32'd0);
        chk({tag, ".dm_rdata"}, dm_rdata, 32'd0);
        chk({tag, ".if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, ".dm_valid"}, {31'd0, dm_valid}, 32'd0);
        chk({tag, ".tick_tock"}, {31'd0, tick_tock}, 32'd0);
    endtask

    // Sample on the falling edge, then let the memory model answer for the next rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("mem_req", {31'd0, mem_req}, {31'd0, busy});
        chk("mem_we", {31'd0, mem_we}, busy ? {31'd0, cur.we} : 32'd0);
        chk("mem_addr", mem_addr, busy ? cur.addr : 32'd0);
        chk("mem_wdata", mem_wdata, busy ? cur.wdata : 32'd0);
        chk("mem_sizesel", {30'd0, mem_sizesel}, busy ? {30'd0, cur.size} : 32'd0);
        chk("if_valid", {31'd0, if_valid}, {31'd0, exp_if_valid});
        chk("dm_valid", {31'd0, dm_valid}, {31'd0, exp_dm_valid});
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("dm_rdata", dm_rdata, exp_dm_rdata);
        step_end = !busy && (q.size() == 0);
        chk("tick_tock", {31'd0, tick_tock}, {31'd0, step_end});
        exp_if_valid = 1'b0;
        exp_dm_valid = 1'b0;
        if (busy) begin
            if (cur.wait_cyc == 0) begin
                mem_ready = 1'b1;
                mem_rdata = cur.rdata;
                busy      = 1'b0;
                if (cur.is_data) begin
                    exp_dm_valid = 1'b1;
                    if (!cur.we) exp_dm_rdata = cur.rdata;
                end else begin
                    exp_if_valid = 1'b1;
                    exp_if_rdata = cur.rdata;
                end
            end else begin
                cur.wait_cyc--;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            // Memory may wave ready while nothing is outstanding; it must be ignored.
            mem_ready = force_spurious ? 1'b1 : 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (q.size() > 0) begin
                cur  = q.pop_front();
                busy = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one pipeline step's requests and hold them until the step is served.
    task automatic run_step(
        input bit ifr, input logic [31:0] ia, input logic [31:0] ird, input int iw,
        input bit dr, input bit we, input logic [31:0] da, input logic [31:0] wd,
        input logic [1:0] sz, input logic [31:0] drd, input int dw
    );
        txn_t t;
        if_req = ifr; if_addr = ia;
        dm_req = dr; dm_we = we; dm_addr = da; dm_wdata = wd; dm_sizesel = sz;
        if (dr) begin
            t = '{is_data: 1'b1, we: we, addr: da, wdata: wd, size: sz, wait_cyc: dw, rdata: drd};
            q.push_back(t);
        end
        if (ifr) begin
            t = '{is_data: 1'b0, we: 1'b0, addr: ia, wdata: 32'd0, size: 2'b00, wait_cyc: iw, rdata: ird};
            q.push_back(t);
        end
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (step_end) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        txn_t        t;
        logic [1:0]  sz;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_sizesel = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        busy = 1'b0; step_end = 1'b0; force_spurious = 1'b0;
        exp_if_valid = 1'b0; exp_dm_valid = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle bubbles with memory asserting ready for no reason.
        force_spurious = 1'b1;
        repeat (5) run_step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        force_spurious = 1'b0;

        run_step(1, 32'h10, 32'h0050_0093, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        run_step(1, 32'h14, 32'h00A0_0113, 0, 1, 0, 32'h40, 0, 2'b00, 32'hDEAD_BEEF, 0);
        run_step(0, 0, 0, 0, 1, 1, 32'h44, 32'hAB, 2'b01, 32'h5555_AAAA, 3);
        run_step(1, 32'h18, 32'h1234_5678, 2, 1, 0, 32'h48, 0, 2'b10, 32'h0000_BEEF, 1);

        // Reset while a store is waiting on memory.
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80;
        dm_wdata = 32'h1234_5678; dm_sizesel = 2'b10;
        t = '{is_data: 1'b1, we: 1'b1, addr: 32'h80, wdata: 32'h1234_5678, size: 2'b10,
              wait_cyc: 100, rdata: 32'h0};
        q.push_back(t);
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_hold");
        rst = 1'b0;
        q.delete();
        busy = 1'b0;
        exp_if_valid = 1'b0; exp_dm_valid = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        @(posedge clk); #1;
        run_step(1, 32'h88, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 2'b00, 0, 0);

        for (int s = 0; s < 150; s++) begin
            sz = 2'($urandom_range(0, 2));
            run_step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 3),
                     $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                     sz, $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
